// File: rtl/pin_entry_ctrl.sv
// PIN-entry controller for the digital safe: collects a hex code from keypad
// events, checks it against a reprogrammable code, and handles lockout and relock.
module pin_entry_ctrl #(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int OPEN_CYCLES = 4096,
  parameter int AUTO_SUBMIT = 0,
  parameter logic [4*DIGITS-1:0] RESET_CODE = 'h1234
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [3:0]                       key_num,
  output logic [4*DIGITS-1:0]              entry,
  output logic [$clog2(DIGITS+1)-1:0]      count,
  output logic                             pass,
  output logic                             fail,
  output logic                             locked,
  output logic                             prog,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries,
  output logic [2:0]                       dbg_state
);

  localparam int CW   = $clog2(DIGITS + 1);
  localparam int TRW  = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0]  FULL       = CW'(DIGITS);
  localparam logic [CW-1:0]  LAST_DIGIT = CW'(DIGITS - 1);
  localparam logic [TRW-1:0] TRIES_MAX  = TRW'(MAX_TRIES);
  localparam logic [TW-1:0]  LOCK_LAST  = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0]  OPEN_LAST  = (OPEN_CYCLES == 0) ? '0 : TW'(OPEN_CYCLES - 1);

  localparam logic [3:0] K_DEL  = 4'he;
  localparam logic [3:0] K_ENT  = 4'hf;
  localparam logic [3:0] K_PROG = 4'hc;

  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_NEWCODE = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t               state_q;
  logic [4*DIGITS-1:0]  entry_q;
  logic [4*DIGITS-1:0]  code_q;
  logic [CW-1:0]        count_q;
  logic [TRW-1:0]       tries_q;
  logic [TW-1:0]        timer_q;
  logic                 pass_q;
  logic                 fail_q;
  logic                 locked_q;
  logic                 prog_q;

  logic [4*DIGITS-1:0]  push_d;
  logic [4*DIGITS-1:0]  pop_d;
  logic [CW-1:0]        count_inc_d;
  logic [CW-1:0]        count_dec_d;
  logic [TRW-1:0]       tries_inc_d;
  logic                 code_match_d;
  logic                 open_timeout_d;
  logic                 auto_check_d;

  assign count_inc_d    = count_q + CW'(1);
  assign count_dec_d    = count_q - CW'(1);
  assign tries_inc_d    = tries_q + TRW'(1);
  // A short entry can never match, even if the code has leading zero nibbles.
  assign code_match_d   = (count_q == FULL) && (entry_q == code_q);
  assign open_timeout_d = (OPEN_CYCLES != 0) && (timer_q == OPEN_LAST);
  assign auto_check_d   = (AUTO_SUBMIT != 0) && (state_q == S_ENTRY) && (count_q == LAST_DIGIT);

  always_comb begin
    push_d = entry_q;
    pop_d  = entry_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (CW'(i) == count_q)     push_d[4*i +: 4] = key_num;
      if (CW'(i) == count_dec_d) pop_d[4*i +: 4]  = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_ENTRY;
      entry_q  <= '0;
      code_q   <= RESET_CODE;
      count_q  <= '0;
      tries_q  <= '0;
      timer_q  <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
      prog_q   <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      case (state_q)
        S_ENTRY, S_NEWCODE: begin
          if (key_valid) begin
            if (key_num == K_ENT) begin
              if (state_q == S_ENTRY) begin
                state_q <= S_CHECK;
              end else begin
                entry_q <= '0;
                count_q <= '0;
                prog_q  <= 1'b0;
                if (count_q == FULL) begin
                  code_q  <= entry_q;
                  state_q <= S_ENTRY;
                end else begin
                  state_q <= S_OPEN;
                  pass_q  <= 1'b1;
                  timer_q <= '0;
                end
              end
            end else if (key_num == K_DEL) begin
              if (count_q != '0) begin
                entry_q <= pop_d;
                count_q <= count_dec_d;
              end
            end else if (count_q != FULL) begin
              entry_q <= push_d;
              count_q <= count_inc_d;
              if (auto_check_d) state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          entry_q <= '0;
          count_q <= '0;
          timer_q <= '0;
          if (code_match_d) begin
            state_q <= S_OPEN;
            pass_q  <= 1'b1;
            tries_q <= '0;
          end else begin
            fail_q  <= 1'b1;
            tries_q <= tries_inc_d;
            if (tries_inc_d == TRIES_MAX) begin
              state_q  <= S_LOCKOUT;
              locked_q <= 1'b1;
            end else begin
              state_q <= S_ENTRY;
            end
          end
        end
        S_OPEN: begin
          timer_q <= timer_q + TW'(1);
          // The timeout takes priority over a key arriving on the same edge.
          if (open_timeout_d) begin
            state_q <= S_ENTRY;
            pass_q  <= 1'b0;
          end else if (key_valid && key_num == K_ENT) begin
            state_q <= S_ENTRY;
            pass_q  <= 1'b0;
          end else if (key_valid && key_num == K_PROG) begin
            state_q <= S_NEWCODE;
            pass_q  <= 1'b0;
            prog_q  <= 1'b1;
          end
        end
        S_LOCKOUT: begin
          timer_q <= timer_q + TW'(1);
          if (timer_q == LOCK_LAST) begin
            state_q  <= S_ENTRY;
            locked_q <= 1'b0;
            tries_q  <= '0;
          end
        end
        default: state_q <= S_ENTRY;
      endcase
    end
  end

  assign entry     = entry_q;
  assign count     = count_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign locked    = locked_q;
  assign prog      = prog_q;
  assign tries     = tries_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: directed and random keypad traffic against a
// behavioural model of the safe; a second instance covers auto-submit.
module tb_pin_entry_ctrl;

  localparam int M_ENTRY = 0;
  localparam int M_CHECK = 1;
  localparam int M_OPEN  = 2;
  localparam int M_NEW   = 3;
  localparam int M_LOCK  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        kv, kv_a;
  logic [3:0]  kn, kn_a;
  logic [15:0] entry, entry_a;
  logic [2:0]  count, count_a;
  logic        pass, fail, locked, prog;
  logic        pass_a, fail_a, locked_a, prog_a;
  logic [1:0]  tries, tries_a;
  logic [2:0]  dbg, dbg_a;

  int n_pass  = 0;
  int n_total = 0;

  // model of the safe
  int          m_mode;
  logic [3:0]  m_buf[$];
  logic [3:0]  m_code[4];
  int          m_tries;
  int          m_age;
  bit          m_fail;

  always #5 clk = ~clk;

  pin_entry_ctrl #(
    .DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(16), .OPEN_CYCLES(32),
    .AUTO_SUBMIT(0), .RESET_CODE(16'h1234)
  ) u_dut (
    .clk(clk), .reset(reset), .key_valid(kv), .key_num(kn),
    .entry(entry), .count(count), .pass(pass), .fail(fail),
    .locked(locked), .prog(prog), .tries(tries), .dbg_state(dbg)
  );

  pin_entry_ctrl #(
    .DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(16), .OPEN_CYCLES(32),
    .AUTO_SUBMIT(1), .RESET_CODE(16'h1234)
  ) u_auto (
    .clk(clk), .reset(reset), .key_valid(kv_a), .key_num(kn_a),
    .entry(entry_a), .count(count_a), .pass(pass_a), .fail(fail_a),
    .locked(locked_a), .prog(prog_a), .tries(tries_a), .dbg_state(dbg_a)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
  endtask

  function automatic logic [15:0] pack_buf();
    logic [15:0] v = '0;
    foreach (m_buf[i]) v[i*4 +: 4] = m_buf[i];
    return v;
  endfunction

  function automatic bit buf_is_code();
    if (m_buf.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_buf[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = M_ENTRY;
    m_buf.delete();
    m_code[0] = 4'h4; m_code[1] = 4'h3; m_code[2] = 4'h2; m_code[3] = 4'h1;
    m_tries = 0;
    m_age   = 0;
    m_fail  = 1'b0;
  endtask

  task automatic model_edit(input logic [3:0] k);
    if (k == 4'he) begin
      if (m_buf.size() > 0) void'(m_buf.pop_back());
    end else if (m_buf.size() < 4) begin
      m_buf.push_back(k);
    end
  endtask

  // One clock edge of the safe as seen from the keypad.
  task automatic model_edge(input bit v, input logic [3:0] k);
    bit full;
    m_fail = 1'b0;
    case (m_mode)
      M_ENTRY: if (v) begin
        if (k == 4'hf) m_mode = M_CHECK;
        else model_edit(k);
      end
      M_CHECK: begin
        if (buf_is_code()) begin
          m_mode = M_OPEN; m_age = 0; m_tries = 0;
        end else begin
          m_fail = 1'b1;
          m_tries++;
          if (m_tries == 3) begin m_mode = M_LOCK; m_age = 0; end
          else m_mode = M_ENTRY;
        end
        m_buf.delete();
      end
      M_OPEN: begin
        m_age++;
        if (m_age == 32) m_mode = M_ENTRY;
        else if (v && k == 4'hf) m_mode = M_ENTRY;
        else if (v && k == 4'hc) m_mode = M_NEW;
      end
      M_NEW: if (v) begin
        if (k == 4'hf) begin
          full = (m_buf.size() == 4);
          if (full) begin
            for (int i = 0; i < 4; i++) m_code[i] = m_buf[i];
            m_mode = M_ENTRY;
          end else begin
            m_mode = M_OPEN; m_age = 0;
          end
          m_buf.delete();
        end else begin
          model_edit(k);
        end
      end
      M_LOCK: begin
        m_age++;
        if (m_age == 16) begin m_mode = M_ENTRY; m_tries = 0; end
      end
      default: m_mode = M_ENTRY;
    endcase
  endtask

  task automatic check_outputs();
    check("entry",  entry,  pack_buf());
    check("count",  count,  m_buf.size());
    check("pass",   pass,   m_mode == M_OPEN);
    check("fail",   fail,   m_fail);
    check("locked", locked, m_mode == M_LOCK);
    check("prog",   prog,   m_mode == M_NEW);
    check("tries",  tries,  m_tries);
  endtask

  // Drive one cycle (called just after a rising edge), then check after the next edge.
  task automatic cycle(input bit v, input logic [3:0] k);
    kv = v;
    kn = k;
    @(posedge clk);
    model_edge(v, k);
    #1;
    kv = 1'b0;
    kn = 4'($urandom);
    check_outputs();
  endtask

  task automatic press(input logic [3:0] k);
    cycle(1'b1, k);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 4'($urandom));
  endtask

  task automatic type_str(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      press((c >= "a") ? 4'(c - "a" + 10) : 4'(c - "0"));
      if (c == "f") idle(2);
    end
  endtask

  task automatic type_code();
    logic [3:0] code_copy[4];
    code_copy = m_code;
    for (int i = 0; i < 4; i++) press(code_copy[i]);
  endtask

  task automatic auto_press(input logic [3:0] k);
    kv_a = 1'b1;
    kn_a = k;
    cycle(1'b0, 4'($urandom));
    kv_a = 1'b0;
  endtask

  task automatic check_auto_zero(input string tag);
    check({tag, ".entry"},  entry_a,  0);
    check({tag, ".count"},  count_a,  0);
    check({tag, ".pass"},   pass_a,   0);
    check({tag, ".fail"},   fail_a,   0);
    check({tag, ".locked"}, locked_a, 0);
    check({tag, ".prog"},   prog_a,   0);
    check({tag, ".tries"},  tries_a,  0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    check_auto_zero("auto_rst");
    #2 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    kv = 1'b0; kn = 4'h0; kv_a = 1'b0; kn_a = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    check_auto_zero("auto_init");
    reset = 1'b0;

    // correct code, then open timeout with no keys
    type_str("4321f");
    idle(40);
    // delete mid-entry
    type_str("439e21f");
    type_str("f");
    // three wrong attempts into lockout, digit during lockout ignored
    type_str("5555f");
    type_str("5555f");
    type_str("5555f");
    press(4'h7);
    idle(20);
    // short entry
    type_str("1f");
    // reprogram to 8765 and exercise new and old codes
    type_str("4321f");
    type_str("c8765f");
    type_str("8765f");
    type_str("f");
    type_str("4321f");
    // key on the timeout edge: timeout must win
    type_str("8765f");
    idle(30);
    press(4'hc);
    idle(2);
    // aborted reprogram returns to OPEN
    type_str("8765f");
    type_str("c87f");
    idle(3);
    type_str("f");

    // random traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          type_code();
          if ($urandom_range(0, 3) != 0) press(4'hf);
        end
        4, 5: press(4'($urandom_range(0, 13)));
        6:    press(4'he);
        7:    press(4'hf);
        8:    press(4'hc);
        default: idle($urandom_range(0, 20));
      endcase
      idle($urandom_range(0, 2));
    end

    // reprogram from a known state, then prove reset restores the code
    pulse_reset();
    type_str("4321f");
    type_str("c9abdf");

    // auto-submit instance
    auto_press(4'h4);
    auto_press(4'h3);
    auto_press(4'h2);
    check("auto_entry3", entry_a, 16'h0234);
    auto_press(4'h1);
    check("auto_pass_n", pass_a, 0);
    check("auto_count_n", count_a, 4);
    cycle(1'b0, 4'h0);
    check("auto_pass_n1", pass_a, 1);
    check("auto_entry_n1", entry_a, 0);
    auto_press(4'hf);
    check("auto_relock", pass_a, 0);
    auto_press(4'h9);
    auto_press(4'h9);
    check("auto_mid_entry", entry_a, 16'h0099);
    check("auto_mid_count", count_a, 2);
    pulse_reset();
    type_str("9abdf");
    type_str("4321f");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
